instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Fetch stage front end: owns the fetch PC, issues in-order requests to a multi-cycle
//  instruction memory, buffers returned words with their PCs, and presents one instruction
//  per cycle to pipeline_f_d. Replaces the combinational instrmem/program_counter path and
//  absorbs decode stalls and branch/jump redirects from execute (PCSrc/PCTargetE).
// PARAMETERS
//  DATA_WIDTH  32            instruction/address width
//  DEPTH       4             queue entries; power of 2, >= 2; also max outstanding requests
//  RESET_PC    32'h00000000  first fetch address after reset
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   reset, synchronous, active-high
//  redirect     in   1   PCSrc from execute: discard everything younger, refetch
//  redirect_pc  in   32  PCTargetE; sampled only when redirect=1
//  stall        in   1   hazard-unit stall: decode does not consume this cycle
//  imem_req     out  1   request valid
//  imem_addr    out  32  request address (word aligned, = fetch_pc)
//  imem_gnt     in   1   request accepted this cycle (req && gnt = handshake)
//  imem_rvalid  in   1   response valid; responses return in request order, no backpressure
//  imem_rdata   in   32  response instruction word
//  InstrF       out  32  head instruction; NOP (32'h00000013) when queue empty
//  PCF          out  32  PC of head instruction
//  PCPlus4F     out  32  PCF + 4 (mod 2^32)
//  valid_f      out  1   head entry valid
// BEHAVIOUR
//  - State: fetch_pc, resp_pc, queue (entries {pc,instr}), count [clog2(DEPTH):0],
//    outstanding [clog2(DEPTH):0], drop_cnt [clog2(DEPTH):0].
//  - Reset (rst=1 at posedge): fetch_pc=resp_pc=RESET_PC; count=outstanding=drop_cnt=0.
//    imem_req forced 0 while rst=1; outputs then valid_f=0, InstrF=NOP, PCF=RESET_PC... 
//    (PCF/PCPlus4F show resp_pc when empty). Reset overrides every other input.
//  - Issue: imem_req = !rst && !redirect && (count + outstanding < DEPTH). On req&&gnt:
//    fetch_pc += 4 (wraps mod 2^32), outstanding++. Credit rule guarantees a response always
//    has a free slot; no overflow possible.
//  - Response: on imem_rvalid, outstanding--. If drop_cnt>0: drop_cnt--, word discarded.
//    Else push {resp_pc, imem_rdata}, resp_pc += 4. Latency: rvalid at cycle N -> valid_f at N+1
//    (no bypass).
//  - Consume: pop when valid_f && !stall. Pop and push same cycle allowed, incl. when full.
//    Pop on empty is a no-op.
//  - Redirect (highest priority after rst): queue cleared (count=0); fetch_pc=resp_pc=redirect_pc;
//    drop_cnt = outstanding after this cycle's response (a response arriving this cycle is
//    discarded and not counted); no request issued this cycle; valid_f=0 next cycle.
//    Redirect with stall: redirect wins. Back-to-back redirects: drop_cnt recomputed each time.
//  - Redirect to unaligned redirect_pc: low 2 bits forced to 0.
//  - Invariants (assert): count+outstanding <= DEPTH; drop_cnt <= outstanding; no push when full.
// STRUCTURE
//  - Shared package cpu_pkg: NOP_INSTR constant, fetch_entry_t struct {pc, instr}.
//  - One sub-module: fetch_fifo (synchronous FIFO of fetch_entry_t, DEPTH param, push/pop/
//    clear, count, head data combinational). Credit/drop logic stays in this module.
// TESTING
//  - Reset, imem gnt=1, 1-cycle response, stall=0 -> PCF 0,4,8,... one per cycle after
//    2-cycle fill; valid_f continuous.
//  - stall=1 for 10 cycles, DEPTH=4 -> count reaches 4, imem_req=0, head PCF held; release ->
//    4 buffered instructions drain in order, no loss/duplication.
//  - 3-cycle memory latency, 3 requests outstanding, redirect to 32'h100 -> next 3 responses
//    dropped, first valid_f shows PCF=32'h100 with mem[0x100].
//  - Redirect same cycle as rvalid and stall=1 -> that response discarded, drop_cnt=outstanding-1,
//    queue empty next cycle.
//  - fetch_pc at 32'hFFFFFFFC -> next request 32'h00000000; PCPlus4F=0 for that entry.
//  - rst asserted mid-burst with outstanding=2 -> next cycle valid_f=0, fetch_pc=RESET_PC,
//    outstanding=0, imem_req low during rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared fetch-stage types and constants (NOP encoding, queue entry).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0 -- what decode sees when the fetch queue has nothing
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Brief  : Synchronous FIFO of fetch entries with clear; head is combinational.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Next pointers and occupancy; clear wins over any same-cycle push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; occupancy gates visibility, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
// ============================================================================
// Module : instr_prefetch_queue
// Brief  : Fetch front end. Owns the fetch PC, issues in-order requests to a
//          multi-cycle instruction memory under a credit limit, buffers the
//          returned words with their PCs and presents one per cycle to decode.
//          Redirects flush the queue and drop in-flight stale responses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_prefetch_queue
  import cpu_pkg::*;
#(
  // The entry struct is XLEN wide; DATA_WIDTH must stay equal to XLEN.
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  valid_f
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_q, drop_d;

  logic [CW-1:0]         fifo_count;
  fetch_entry_t          fifo_head;
  fetch_entry_t          fifo_wdata;
  logic                  fifo_push, fifo_pop;

  logic [CW:0]           credit_used;
  logic                  issue, resp_drop;
  logic [DATA_WIDTH-1:0] redirect_aligned;

  // Every issued request owns a queue slot until it is consumed, so a
  // response can never find the queue full.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req    = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign issue       = imem_req && imem_gnt;

  // Responses belonging to requests issued before a redirect are discarded.
  assign resp_drop  = imem_rvalid && (drop_q != '0);
  assign fifo_push  = imem_rvalid && !resp_drop && !redirect;
  assign fifo_pop   = valid_f && !stall && !redirect;
  assign fifo_wdata = '{pc: resp_pc_q, instr: imem_rdata};

  assign redirect_aligned = redirect_pc & ~DATA_WIDTH'(3);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  // Next fetch/response PCs and credit counters; redirect overrides all.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
    drop_d        = drop_q - CW'(resp_drop);
    if (issue)     fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
    if (fifo_push) resp_pc_d  = resp_pc_q + DATA_WIDTH'(4);
    if (redirect) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      // Everything still in flight after this cycle's response is stale.
      drop_d     = outstanding_q - CW'(imem_rvalid);
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // When empty, PCF shows the PC the next pushed word will carry.
  assign valid_f  = (fifo_count != '0);
  assign InstrF   = valid_f ? fifo_head.instr : NOP_INSTR;
  assign PCF      = valid_f ? fifo_head.pc : resp_pc_q;
  assign PCPlus4F = PCF + DATA_WIDTH'(4);

  a_credit_bound : assert property (@(posedge clk) disable iff (rst)
    credit_used <= (CW+1)'(DEPTH));
  a_drop_bound : assert property (@(posedge clk) disable iff (rst)
    drop_q <= outstanding_q);
  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && (fifo_count == CW'(DEPTH)) && !fifo_pop));
  a_no_spurious_rvalid : assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outstanding_q == '0)));

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
// ============================================================================
// Module : tb_instr_prefetch_queue
// Brief  : Directed + random bench for instr_prefetch_queue against a
//          queue-based reference model and an in-order latency memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_prefetch_queue;
  import cpu_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, redirect, stall, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, valid_f;
  logic [31:0] imem_addr, InstrF, PCF, PCPlus4F;

  instr_prefetch_queue #(
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .valid_f     (valid_f)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory environment: accepted requests waiting to be answered in order
  typedef struct { logic [31:0] addr; int due; } pend_t;
  // reference model: requests in flight (stale after a redirect), buffered words
  typedef struct { logic [31:0] addr; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  pend_t       mem_q[$];
  fl_t         m_fl[$];
  ent_t        m_q[$];
  logic [31:0] m_fetch, m_next;
  int          last_due;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic bit mem_due();
    return (mem_q.size() > 0) && (mem_q[0].due <= cyc);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit r, input bit rd, input bit st, input bit g,
                      input logic [31:0] rpc);
    bit          do_resp, exp_valid, exp_req, pop_m;
    logic [31:0] exp_pc;
    int          due;
    pend_t       p;
    fl_t         f;
    ent_t        e;

    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    stall       = st;
    imem_gnt    = g;
    do_resp     = !r && mem_due();
    imem_rvalid = do_resp;
    imem_rdata  = do_resp ? mem_word(mem_q[0].addr) : 32'hDEADBEEF;
    #1;

    exp_valid = (m_q.size() > 0);
    exp_pc    = exp_valid ? m_q[0].pc : m_next;
    check("valid_f", 32'(valid_f), 32'(exp_valid));
    check("PCF", PCF, exp_pc);
    check("PCPlus4F", PCPlus4F, exp_pc + 32'd4);
    check("InstrF", InstrF, exp_valid ? m_q[0].instr : NOP_INSTR);
    exp_req = !r && !rd && ((m_q.size() + m_fl.size()) < DEPTH);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m_fetch);

    // memory answers whatever the DUT actually presented
    if (imem_req && g) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back('{addr: imem_addr, due: due});
      last_due = due;
    end
    if (do_resp) p = mem_q.pop_front();

    if (r) begin
      m_q.delete();
      m_fl.delete();
      mem_q.delete();
      m_fetch  = RESET_PC;
      m_next   = RESET_PC;
      last_due = cyc;
    end else begin
      pop_m = exp_valid && !st && !rd;
      if (pop_m) e = m_q.pop_front();
      if (do_resp && (m_fl.size() > 0)) begin
        f = m_fl.pop_front();
        if (!f.stale && !rd) begin
          m_q.push_back('{pc: f.addr, instr: mem_word(f.addr)});
          m_next = f.addr + 32'd4;
        end
      end
      if (exp_req && g) begin
        m_fl.push_back('{addr: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
      if (rd) begin
        m_q.delete();
        foreach (m_fl[i]) m_fl[i].stale = 1'b1;
        m_fetch = rpc & ~32'd3;
        m_next  = rpc & ~32'd3;
      end
    end

    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    m_fetch = RESET_PC; m_next = RESET_PC; last_due = 0;
    repeat (2) @(negedge clk);

    // reset state visible while rst is still held
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);

    // streaming with single-cycle memory, no stalls
    lat_min = 1; lat_max = 1;
    repeat (20) step(0, 0, 0, 1, 0);

    // decode stall fills the queue, then drains in order
    repeat (10) step(0, 0, 1, 1, 0);
    repeat (12) step(0, 0, 0, 1, 0);

    // three-cycle memory, redirect with requests in flight
    lat_min = 3; lat_max = 3;
    repeat (6) step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 32'h100);
    repeat (15) step(0, 0, 0, 1, 0);

    // redirect with stall on the very cycle a response returns
    lat_min = 2; lat_max = 2;
    repeat (3) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      if (mem_due()) begin
        step(0, 1, 1, 1, 32'h180);
        break;
      end
      step(0, 0, 0, 1, 0);
    end
    repeat (8) step(0, 0, 0, 1, 0);

    // fetch PC wraps through 32'hFFFFFFFC to 0
    lat_min = 1; lat_max = 1;
    step(0, 1, 0, 1, 32'hFFFF_FFF4);
    repeat (8) step(0, 0, 0, 1, 0);

    // unaligned redirect target is word-aligned
    step(0, 1, 0, 1, 32'h0000_0203);
    repeat (6) step(0, 0, 0, 1, 0);

    // reset mid-burst with two requests outstanding
    lat_min = 3; lat_max = 3;
    step(0, 1, 0, 1, 32'h300);
    for (int i = 0; i < 10; i++) begin
      if (m_fl.size() == 2) break;
      step(0, 0, 0, 1, 0);
    end
    step(1, 0, 0, 1, 0);
    repeat (6) step(0, 0, 0, 1, 0);

    // random traffic: latency, grants, stalls, redirects and rare resets
    lat_min = 1; lat_max = 4;
    repeat (400) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0,
           $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
